// File: rtl/seq_detect_pkg.sv
// Shared types and default widths for the serial pattern detection controller.
package seq_detect_pkg;

   localparam int unsigned DEF_PAT_W = 8;
   localparam int unsigned DEF_LEN_W = 4;
   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned DEF_WIN_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Shift-register history with a fresh-bit counter and a length-masked pattern compare.
module seq_match_core #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             shift_en,
   input  logic             flush,
   input  logic             bit_in,
   input  logic [LEN_W-1:0] len,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] cand;
   logic [LEN_W-1:0] seen;
   logic             seen_ok;
   logic             cmp_ok;

   assign cand    = {hist[PAT_W-2:0], bit_in};
   assign seen_ok = ((LEN_W+1)'(seen) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);

   // Only bit positions below len take part in the compare.
   always_comb begin
      cmp_ok = 1'b1;
      for (int i = 0; i < PAT_W; i++) begin
         if ((LEN_W'(i) < len) && (cand[i] != pattern[i])) begin
            cmp_ok = 1'b0;
         end
      end
   end

   assign match = shift_en && seen_ok && cmp_ok;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hist <= '0;
         seen <= '0;
      end else if (flush) begin
         hist <= '0;
         seen <= '0;
      end else if (shift_en) begin
         hist <= cand;
         seen <= (seen == LEN_W'(PAT_W)) ? seen : seen + LEN_W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detection controller: config port, run FSM, hit and window counters.
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W,
   parameter int unsigned LEN_W = DEF_LEN_W,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned WIN_W = DEF_WIN_W
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [WIN_W-1:0] cfg_window,
   output logic             cfg_err,
   input  logic             start,
   input  logic             abort,
   input  logic             signal_in,
   output logic             busy,
   output logic             match_pulse,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             done,
   output logic             timeout
);

   state_t           state;
   state_t           state_nx;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;
   logic [CNT_W-1:0] tgt_q;
   logic [WIN_W-1:0] win_q;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] hit_inc;
   logic             cfg_fire;
   logic             len_ok;
   logic             start_go;
   logic             step;
   logic             match;
   logic             tgt_hit;
   logic             win_exp;
   logic             core_flush;

   assign cfg_fire   = cfg_valid && cfg_ready;
   assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
   assign start_go   = (state != ARMED) && start && !abort;
   assign step       = (state == ARMED) && !abort;
   assign hit_inc    = (hit_cnt == '1) ? hit_cnt : hit_cnt + CNT_W'(1);
   assign tgt_hit    = match && (tgt_q != '0) &&
                       (((CNT_W+1)'(hit_cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(tgt_q));
   assign win_exp    = step && (win_q != '0) && ((win_cnt + WIN_W'(1)) == win_q);
   // Non-overlap mode restarts the history so the next hit needs len fresh bits.
   assign core_flush = start_go || (match && !ovl_q);

   seq_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .clk      (clk),
      .rst_b    (rst_b),
      .shift_en (step),
      .flush    (core_flush),
      .bit_in   (signal_in),
      .len      (len_q),
      .pattern  (pat_q),
      .match    (match)
   );

   // Abort wins over everything, including a coincident start.
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start) state_nx = ARMED;
            ARMED:      if (tgt_hit || win_exp) state_nx = DONE;
            default:    state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= IDLE;
         pat_q       <= '0;
         len_q       <= LEN_W'(1);
         ovl_q       <= 1'b0;
         tgt_q       <= '0;
         win_q       <= '0;
         win_cnt     <= '0;
         cfg_ready   <= 1'b0;
         cfg_err     <= 1'b0;
         busy        <= 1'b0;
         match_pulse <= 1'b0;
         hit_cnt     <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nx;
         cfg_ready   <= (state_nx != ARMED);
         busy        <= (state_nx == ARMED);
         cfg_err     <= cfg_fire && !len_ok;
         match_pulse <= match;
         done        <= tgt_hit || win_exp;

         if (cfg_fire && len_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
            win_q <= cfg_window;
         end

         // hit_cnt and timeout are left alone on abort so software can read them back.
         if (start_go) begin
            hit_cnt <= '0;
            timeout <= 1'b0;
            win_cnt <= '0;
         end else if (step) begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (match) hit_cnt <= hit_inc;
            if (tgt_hit || win_exp) timeout <= win_exp && !tgt_hit;
         end
      end
   end

endmodule
